dedup_lane_merger: RTL and testbench
====================================

// Module: dedup_lane_merger
// PURPOSE
//  Consumer end of the 4-lane dedup output interface (out_N / out_valid_N).
//  Lanes present registered, sticky values. A lane's valid stays high and its data is held for many cycles.
//  This block turns those level-style lanes into discrete events and buffers one event per lane.
//  It merges the events round-robin onto one valid/ready stream feeding downstream logic.
// PARAMETERS
//  DATA_W   8   width of each lane value and of data_out
//  CNT_W    16  width of drop_count (only with MERGER_DROP_CNT_EN)
// PORTS
//  clk_in       in   1            single clock, rising edge
//  reset_in     in   1            asynchronous reset, active-high
//  in_0..in_3   in   DATA_W       lane values
//  in_valid_0..in_valid_3  in  1  lane valid flags
//  data_out     out  DATA_W       merged value
//  lane_out     out  2            source lane index of data_out
//  out_valid    out  1            data_out/lane_out valid
//  out_ready    in   1            downstream accepts when out_valid && out_ready
//  drop_count   out  CNT_W        dropped-event counter (MERGER_DROP_CNT_EN only)
// BEHAVIOUR
//  Reset (async, reset_in=1): every register is cleared and the block holds no pending event.
//   - outputs: data_out=0, lane_out=0, out_valid=0, drop_count=0.
//   - internal: rr_ptr=0, all pend/prev state cleared.
//   - reset asserted mid-transfer: any pending or presented event is lost, and no out_valid glitch occurs.
//  Event detect, per lane i:
//   - registers prev_valid_i and prev_data_i each cycle.
//   - event_i = in_valid_i && (!prev_valid_i || in_i != prev_data_i).
//   - a steady held value produces exactly one event.
//  Lane slot, per lane i: pend_i plus pend_data_i.
//   - on event_i: if slot empty, or slot granted this same cycle, the slot loads in_i.
//   - otherwise the new event is dropped and the old slot content is kept.
//  Output stage: one register. Load condition is load = !out_valid || out_ready.
//   - on load, grant the first pending lane scanning rr_ptr, rr_ptr+1, ... (mod 4).
//   - the granted slot clears; data_out/lane_out take its value and index; out_valid=1.
//   - rr_ptr <= grant+1 (2-bit wrap 3->0).
//   - on load with nothing pending: out_valid=0 and data_out/lane_out hold.
//   - while out_valid && !out_ready, data_out/lane_out/out_valid are held stable.
//  Latency: input change sampled at edge N -> slot at edge N -> out_valid at edge N+1 (output idle, lane granted).
//  Throughput: 1 event/cycle with out_ready tied high.
//  Simultaneous: a lane event in the same cycle its slot is granted is kept, not dropped.
//  in_valid falling then rising with the same value counts as a new event.
// CONFIGURATION
//  `define MERGER_DROP_CNT_EN
//   - with the macro: drop_count port exists.
//   - it increments by the number of lanes dropping in that cycle (0..4) and saturates at all-ones.
//  Without the macro: the port and counter are absent; drops are silent. Data behaviour is identical.
// STRUCTURE
//  Package dedup_pkg holds:
//   - LANES = 4
//   - typedef logic [1:0] lane_idx_t
//   - typedef struct {logic [DATA_W-1:0] data; lane_idx_t lane;} lane_evt_t (parameterised via localparam DATA_W=8 default)
//  Sub-module dedup_lane_capture holds per-lane prev registers, event detect and slot. It is instantiated 4x.
//  Arbiter and output stage stay in the top.
// TESTING
//  1. Reset: assert reset_in mid-run, async -> all outputs 0 before the next clk edge; out_valid stays 0 after release.
//  2. Sticky input: in_valid_0=1, in_0=8'h5A held 20 cycles, out_ready=1.
//     -> exactly one beat data_out=5A lane_out=0, out_valid 2 cycles after the first drive.
//  3. Round-robin: all 4 lanes fire at once (11,22,33,44), out_ready=1.
//     -> beats lane 0,1,2,3 on consecutive cycles.
//     Then lanes 0 and 2 fire -> grants lane 0 then 2 (rr_ptr=0 after wrap).
//  4. Backpressure: out_ready=0 with lane 1 event 77 -> out_valid=1, data_out=77 held stable 10 cycles; accepted on the first out_ready=1.
//  5. Overflow: out_ready=0, lane 1 holds 77 in output, lane 2 slot=01, lane 2 changes to 02.
//     -> 02 dropped, drop_count=1 (macro on).
//     -> after release, beats 77 then 01 only.
//  6. Same-cycle refill: lane 3 slot granted while lane 3 changes 0A->0B -> 0A then 0B both emitted, drop_count unchanged.

Source files
------------

// File: rtl/dedup_pkg.sv
// dedup_pkg: shared lane count, lane index and event types for the dedup lane merger.
package dedup_pkg;
    localparam int LANES = 4;
    localparam int DATA_W = 8;
    typedef logic [1:0] lane_idx_t;
    typedef struct packed {
        logic [DATA_W-1:0] data;
        lane_idx_t         lane;
    } lane_evt_t;
endpackage

// File: rtl/dedup_lane_capture.sv
// dedup_lane_capture: turns one sticky lane into discrete events held in a one-deep slot.
// MERGER_DROP_CNT_EN adds the drop output used by the merger's drop counter.
module dedup_lane_capture #(
    parameter int DATA_W = 8
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              grant,
    output logic              pend,
    output logic [DATA_W-1:0] pend_data
`ifdef MERGER_DROP_CNT_EN
    ,
    output logic              drop
`endif
);
    logic              prev_valid;
    logic [DATA_W-1:0] prev_data;
    logic              evt;

    assign evt = in_valid && (!prev_valid || in_data != prev_data);
`ifdef MERGER_DROP_CNT_EN
    assign drop = evt && pend && !grant;
`endif

    // a slot granted this cycle is free again, so a simultaneous event refills it
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            prev_valid <= 1'b0;
            prev_data  <= '0;
            pend       <= 1'b0;
            pend_data  <= '0;
        end else begin
            prev_valid <= in_valid;
            prev_data  <= in_data;
            if (evt && (!pend || grant)) begin
                pend      <= 1'b1;
                pend_data <= in_data;
            end else if (grant) begin
                pend <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/dedup_lane_merger.sv
// dedup_lane_merger: detects events on 4 sticky lanes and merges them round-robin onto one valid/ready stream.
// MERGER_DROP_CNT_EN adds a saturating drop_count port.
module dedup_lane_merger
    import dedup_pkg::*;
#(
    parameter int DATA_W = 8
`ifdef MERGER_DROP_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic [DATA_W-1:0] in_0,
    input  logic [DATA_W-1:0] in_1,
    input  logic [DATA_W-1:0] in_2,
    input  logic [DATA_W-1:0] in_3,
    input  logic              in_valid_0,
    input  logic              in_valid_1,
    input  logic              in_valid_2,
    input  logic              in_valid_3,
    output logic [DATA_W-1:0] data_out,
    output lane_idx_t         lane_out,
    output logic              out_valid,
    input  logic              out_ready
`ifdef MERGER_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0]  drop_count
`endif
);
    logic [DATA_W-1:0] lane_in   [LANES];
    logic [DATA_W-1:0] pend_data [LANES];
    logic [LANES-1:0]  lane_vld;
    logic [LANES-1:0]  pend;
    logic [LANES-1:0]  grant;
    lane_idx_t         rr_ptr;
    lane_idx_t         gidx;
    logic              found;
    logic              load;

    assign lane_in  = '{in_0, in_1, in_2, in_3};
    assign lane_vld = {in_valid_3, in_valid_2, in_valid_1, in_valid_0};
    assign load     = !out_valid || out_ready;
    assign grant    = {LANES{load && found}} & (LANES'(1) << gidx);

`ifdef MERGER_DROP_CNT_EN
    logic [LANES-1:0] drop;
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dedup_lane_capture #(.DATA_W(DATA_W)) u_cap (
            .clk_in    (clk_in),
            .reset_in  (reset_in),
            .in_data   (lane_in[i]),
            .in_valid  (lane_vld[i]),
            .grant     (grant[i]),
            .pend      (pend[i]),
            .pend_data (pend_data[i])
`ifdef MERGER_DROP_CNT_EN
            ,
            .drop      (drop[i])
`endif
        );
    end

    // scan downwards so the lane closest to rr_ptr wins
    always_comb begin
        found = 1'b0;
        gidx  = rr_ptr;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (pend[rr_ptr + lane_idx_t'(k)]) begin
                found = 1'b1;
                gidx  = rr_ptr + lane_idx_t'(k);
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            lane_out  <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            out_valid <= found;
            if (found) begin
                data_out <= pend_data[gidx];
                lane_out <= gidx;
                rr_ptr   <= gidx + 1'b1;
            end
        end
    end

`ifdef MERGER_DROP_CNT_EN
    logic [2:0]     drop_n;
    logic [CNT_W:0] cnt_sum;

    assign drop_n  = 3'(drop[0]) + 3'(drop[1]) + 3'(drop[2]) + 3'(drop[3]);
    assign cnt_sum = {1'b0, drop_count} + (CNT_W + 1)'(drop_n);

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) drop_count <= '0;
        else          drop_count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
`endif
endmodule

// File: tb/tb_dedup_lane_merger.sv
// tb_dedup_lane_merger: directed bench for dedup_lane_merger; drop_count checked when MERGER_DROP_CNT_EN is set.
module tb_dedup_lane_merger;
    logic       clk_in = 1'b0;
    logic       reset_in = 1'b1;
    logic [7:0] in_0 = '0, in_1 = '0, in_2 = '0, in_3 = '0;
    logic       in_valid_0 = 1'b0, in_valid_1 = 1'b0, in_valid_2 = 1'b0, in_valid_3 = 1'b0;
    logic [7:0] data_out;
    logic [1:0] lane_out;
    logic       out_valid;
    logic       out_ready = 1'b1;
`ifdef MERGER_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [9:0] beats[$];

    dedup_lane_merger #(.DATA_W(8)) dut (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .in_0       (in_0),
        .in_1       (in_1),
        .in_2       (in_2),
        .in_3       (in_3),
        .in_valid_0 (in_valid_0),
        .in_valid_1 (in_valid_1),
        .in_valid_2 (in_valid_2),
        .in_valid_3 (in_valid_3),
        .data_out   (data_out),
        .lane_out   (lane_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef MERGER_DROP_CNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    always #5 clk_in = ~clk_in;

    // a beat presented with ready at the falling edge is taken on the next rising edge
    always @(negedge clk_in)
        if (!reset_in && out_valid && out_ready) beats.push_back({lane_out, data_out});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic chk_drops(input string tag, input int exp);
`ifdef MERGER_DROP_CNT_EN
        chk(tag, 32'(drop_count), 32'(exp));
`endif
    endtask

    initial begin
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_lane", 32'(lane_out), 0);
        chk_drops("rst_drops", 0);
        tick(2);
        reset_in = 1'b0;
        tick();

        // sticky value: exactly one beat, out_valid two edges after drive
        beats.delete();
        in_0 = 8'h5A;
        in_valid_0 = 1'b1;
        tick();
        chk("sticky_early", 32'(out_valid), 0);
        tick();
        chk("sticky_valid", 32'(out_valid), 1);
        chk("sticky_data", 32'(data_out), 32'h5A);
        chk("sticky_lane", 32'(lane_out), 0);
        tick(18);
        chk("sticky_count", beats.size(), 1);
        chk("sticky_beat", 32'(beats[0]), 32'({2'd0, 8'h5A}));
        in_valid_0 = 1'b0;
        tick(2);

        // async reset while a beat is presented and stalled
        out_ready = 1'b0;
        in_1 = 8'h99;
        in_valid_1 = 1'b1;
        tick(2);
        chk("prerst_valid", 32'(out_valid), 1);
        #2;
        reset_in = 1'b1;
        #1;
        chk("async_valid", 32'(out_valid), 0);
        chk("async_data", 32'(data_out), 0);
        chk("async_lane", 32'(lane_out), 0);
        in_valid_1 = 1'b0;
        tick(2);
        reset_in = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("postrst_idle", 32'(out_valid), 0);
        end

        // round robin over all four lanes
        in_0 = 8'h11; in_1 = 8'h22; in_2 = 8'h33; in_3 = 8'h44;
        in_valid_0 = 1'b1; in_valid_1 = 1'b1; in_valid_2 = 1'b1; in_valid_3 = 1'b1;
        tick(2);
        for (int l = 0; l < 4; l++) begin
            chk("rr_valid", 32'(out_valid), 1);
            chk("rr_lane", 32'(lane_out), 32'(l));
            chk("rr_data", 32'(data_out), 32'(8'h11 * (l + 1)));
            tick();
        end
        chk("rr_idle", 32'(out_valid), 0);
        in_0 = 8'h55;
        in_2 = 8'h66;
        tick(2);
        chk("rr2_lane_a", 32'(lane_out), 0);
        chk("rr2_data_a", 32'(data_out), 32'h55);
        tick();
        chk("rr2_lane_b", 32'(lane_out), 2);
        chk("rr2_data_b", 32'(data_out), 32'h66);
        tick();

        // backpressure holds the presented beat
        beats.delete();
        out_ready = 1'b0;
        in_1 = 8'h77;
        tick(2);
        for (int c = 0; c < 10; c++) begin
            chk("bp_hold_valid", 32'(out_valid), 1);
            chk("bp_hold_data", 32'({lane_out, data_out}), 32'({2'd1, 8'h77}));
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_accepted", 32'(out_valid), 0);
        chk("bp_count", beats.size(), 1);
        chk("bp_beat", 32'(beats[0]), 32'({2'd1, 8'h77}));
        chk_drops("bp_drops", 0);

        // overflow: lane 1 re-fires by valid toggle, lane 2 slot full when it changes again
        beats.delete();
        out_ready = 1'b0;
        in_valid_1 = 1'b0;
        tick();
        in_valid_1 = 1'b1;
        tick(2);
        chk("ov_present", 32'({lane_out, data_out}), 32'({2'd1, 8'h77}));
        in_2 = 8'h01;
        tick();
        in_2 = 8'h02;
        tick();
        chk_drops("ov_drops", 1);
        tick(2);
        out_ready = 1'b1;
        tick(4);
        chk("ov_count", beats.size(), 2);
        chk("ov_beat0", 32'(beats[0]), 32'({2'd1, 8'h77}));
        chk("ov_beat1", 32'(beats[1]), 32'({2'd2, 8'h01}));

        // lane 3 changes in the very cycle its slot is granted
        beats.delete();
        in_3 = 8'h0A;
        tick();
        in_3 = 8'h0B;
        tick(4);
        chk("refill_count", beats.size(), 2);
        chk("refill_beat0", 32'(beats[0]), 32'({2'd3, 8'h0A}));
        chk("refill_beat1", 32'(beats[1]), 32'({2'd3, 8'h0B}));
        chk_drops("refill_drops", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
